// File: rtl/vc_pop_arbiter.sv
// Round-robin pop arbiter sharing one downstream path among four VC FIFOs.
// Optional per-channel grant counters are enabled by defining ARB_STATS_EN.
module vc_pop_arbiter #(
    parameter int unsigned BW    = 6,
    parameter int unsigned BURST = 4,
    parameter int unsigned CW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic [3:0]        pausa_in,
    input  logic [3:0]        empty_in,
    input  logic [4*BW-1:0]   data_in,
    input  logic              dest_full_in,
    output logic [3:0]        pop_out,
    output logic [1:0]        grant_out,
    output logic [BW-1:0]     data_out,
    output logic              valid_out
`ifdef ARB_STATS_EN
    ,
    output logic [4*CW-1:0]   grant_cnt_out
`endif
);

    localparam int unsigned CNTW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state, stateNext;
    logic [1:0]      owner, ownerNext;
    logic [CNTW-1:0] cnt, cntNext;
    logic [1:0]      grantNext;
    logic [BW-1:0]   dataNext;
    logic            validNext;
    logic [3:0]      eligible;
    logic [1:0]      sel;
    logic [1:0]      idx;
    logic            found;
    logic            keep;
    logic            go;

    if (BURST < 1 || BURST > 15 || CW < 1) begin : gBadCfg
        $error("vc_pop_arbiter: BURST must be 1..15 and CW at least 1");
    end

    // Next-state, selection and combinational pop strobe
    always_comb begin
        stateNext = state;
        ownerNext = owner;
        cntNext   = cnt;
        grantNext = grant_out;
        dataNext  = data_out;
        validNext = 1'b0;
        pop_out   = 4'b0;
        idx       = 2'd0;
        found     = 1'b0;

        eligible = ~empty_in & ~pausa_in;
        keep     = (state != IDLE) && eligible[owner] && (cnt < CNTW'(BURST));

        // owner is scanned last so it only re-wins when it is alone
        sel = owner;
        for (int k = 1; k <= 4; k++) begin
            idx = owner + 2'(k);
            if (!found && eligible[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        if (keep) begin
            sel = owner;
        end

        go = enb & ~rst & ~dest_full_in & (|eligible);

        if (go) begin
            pop_out   = 4'b0001 << sel;
            stateNext = SERVE;
            ownerNext = sel;
            grantNext = sel;
            dataNext  = data_in[int'(sel)*BW +: BW];
            validNext = 1'b1;
            cntNext   = keep ? cnt + CNTW'(1) : CNTW'(1);
        end else if (enb) begin
            if (dest_full_in && (state != IDLE)) begin
                stateNext = STALL;
            end else if (~|eligible) begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd3;
            cnt       <= '0;
            grant_out <= 2'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            cnt       <= cntNext;
            grant_out <= grantNext;
            data_out  <= dataNext;
            valid_out <= validNext;
        end
    end

`ifdef ARB_STATS_EN
    logic [CW-1:0] grantCnt [4];

    // Saturating per-channel grant counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                grantCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pop_out[i] && (grantCnt[i] != {CW{1'b1}})) begin
                    grantCnt[i] <= grantCnt[i] + CW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : gCntOut
        assign grant_cnt_out[g*CW +: CW] = grantCnt[g];
    end
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: expected grant sequence per step,
// popped heads go through a scoreboard queue and are checked one cycle later.
module tb_vc_pop_arbiter;

    localparam int unsigned BW    = 6;
    localparam int unsigned BURST = 4;
    localparam int unsigned CW    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enb;
    logic [3:0]        pausa_in;
    logic [3:0]        empty_in;
    logic [4*BW-1:0]   data_in;
    logic              dest_full_in;
    logic [3:0]        pop_out;
    logic [1:0]        grant_out;
    logic [BW-1:0]     data_out;
    logic              valid_out;
`ifdef ARB_STATS_EN
    logic [4*CW-1:0]   grant_cnt_out;
`endif

    typedef struct packed {
        logic [1:0]    ch;
        logic [BW-1:0] data;
    } exp_t;

    exp_t            sb[$];
    int              nCmp  = 0;
    int              nFail = 0;
    logic [3:0]      seqNo [4];
    logic            useRand;
    logic [4*BW-1:0] randData;

    vc_pop_arbiter #(.BW(BW), .BURST(BURST), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .pausa_in     (pausa_in),
        .empty_in     (empty_in),
        .data_in      (data_in),
        .dest_full_in (dest_full_in),
        .pop_out      (pop_out),
        .grant_out    (grant_out),
        .data_out     (data_out),
        .valid_out    (valid_out)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt_out(grant_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    // FIFO heads: {channel, sequence number}, advanced by the bench on each expected pop
    always_comb begin
        data_in = randData;
        if (!useRand) begin
            for (int i = 0; i < 4; i++) begin
                data_in[i*BW +: BW] = {2'(i), seqNo[i]};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs applied; expCh < 0 means no pop this cycle
    task automatic tick(input int expCh);
        logic [3:0] expPop;
        exp_t       e;
        expPop = (expCh >= 0) ? (4'b0001 << expCh) : 4'b0000;
        #1;
        chk("pop_out", 32'(pop_out), 32'(expPop));
        if (expCh >= 0) begin
            e.ch   = 2'(expCh);
            e.data = {2'(expCh), seqNo[expCh]};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (expCh >= 0) seqNo[expCh] = seqNo[expCh] + 4'd1;
        @(negedge clk);
        if (expCh >= 0) begin
            e = sb.pop_front();
            chk("valid_out", 32'(valid_out), 32'd1);
            chk("data_out", 32'(data_out), 32'(e.data));
            chk("grant_out", 32'(grant_out), 32'(e.ch));
        end else begin
            chk("valid_idle", 32'(valid_out), 32'd0);
        end
    endtask

    task automatic tickN(input int ch, input int n);
        for (int i = 0; i < n; i++) tick(ch);
    endtask

    task automatic chkResetOuts();
        chk("rst_pop", 32'(pop_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_grant", 32'(grant_out), 32'd0);
`ifdef ARB_STATS_EN
        chk("rst_stats", grant_cnt_out, 32'd0);
`endif
    endtask

    initial begin
        rst          = 1'b1;
        enb          = 1'b1;
        useRand      = 1'b1;
        randData     = '0;
        pausa_in     = 4'b0;
        empty_in     = 4'b0;
        dest_full_in = 1'b0;
        for (int i = 0; i < 4; i++) seqNo[i] = 4'd0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            randData     = (4*BW)'($urandom);
            pausa_in     = 4'($urandom);
            empty_in     = 4'($urandom);
            dest_full_in = 1'($urandom);
            enb          = 1'($urandom);
            #1;
            chkResetOuts();
        end

        @(negedge clk);
        useRand = 1'b0; pausa_in = 4'b0; empty_in = 4'b0; dest_full_in = 1'b0; enb = 1'b1;
        rst = 1'b0;

        // Fair rotation
        tickN(0, 4); tickN(1, 4); tickN(2, 4); tickN(3, 4); tick(0);

        // Pause channel 0 mid-burst, then it returns for a fresh burst of 4
        tick(0);
        pausa_in = 4'b0001;
        tick(1);
        pausa_in = 4'b0000; empty_in = 4'b1100;
        tickN(1, 3); tickN(0, 4); tick(1);

        // Backpressure at channel 1 with cnt=2
        tick(1);
        empty_in = 4'b0000; dest_full_in = 1'b1;
        tickN(-1, 3);
        dest_full_in = 1'b0;
        tickN(1, 2); tick(2);

        // Enable low mid-burst
        tick(2);
        enb = 1'b0;
        tickN(-1, 2);
        enb = 1'b1;
        tickN(2, 2); tick(3);

        // Sole eligible channel keeps popping past BURST
        empty_in = 4'b1011;
        tickN(2, 6);

        // Nothing eligible, then resume from owner 2
        empty_in = 4'b1111;
        tick(-1);
        empty_in = 4'b0000;
        tickN(3, 2);

        // Async reset mid-burst
        #1 rst = 1'b1;
        #1 chkResetOuts();
        @(posedge clk);
        #1 chkResetOuts();
        @(negedge clk);
        rst = 1'b0;
        tickN(0, 4); tick(1);

        nCmp++;
        assert (sb.size() == 0) else begin
            nFail++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/vc_pop_arbiter.md
# vc_pop_arbiter

Round-robin pop arbiter that shares one downstream path between the four virtual-channel FIFOs governed by the flow-control FSM. Each cycle it picks one eligible FIFO: non-empty, and not paused by the FSM's `pausa` vector. It pops that FIFO and registers the word toward the downstream FIFO. Bounded bursts per channel provide fairness, and it backs off whenever the downstream FIFO reports almost-full.

## Interface
- `BW`, 6, data width of each VC FIFO word
- `BURST`, 4, max consecutive pops granted to one channel before forced rotation (1..15)
- `CW`, 8, width of each grant counter (used only with `ARB_STATS_EN`)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `enb`  in  1  block enable; low freezes all state, no pops
- `pausa_in`  in  4  per-channel pause from flow-control FSM; 1 = channel ineligible
- `empty_in`  in  4  per-channel VC FIFO empty flag
- `data_in`  in  4*BW  first-word-fall-through heads; channel i at `[i*BW +: BW]`
- `dest_full_in`  in  1  downstream FIFO almost-full; 1 = do not pop
- `pop_out`  out  4  one-hot pop strobe to VC FIFOs (combinational)
- `grant_out`  out  2  registered index of last granted channel
- `data_out`  out  BW  registered popped word
- `valid_out`  out  1  registered; 1 = `data_out` holds a new word this cycle
- `grant_cnt_out`  out  4*CW  per-channel grant counters (only with `ARB_STATS_EN`)

## Operation
- `eligible[i] = ~empty_in[i] & ~pausa_in[i]`.
- States are IDLE, SERVE, and STALL. The block also holds `owner` (2b) and burst counter `cnt` (0..BURST).
- Continue rule: state is SERVE or STALL, `eligible[owner]`, and `cnt < BURST` → `sel = owner`.
- Rotate rule (otherwise): `sel` is the first eligible channel scanning `owner+1, owner+2, owner+3, owner`, modulo 4. `owner` is checked last, so it re-wins only if alone.
- `go = enb & ~rst & ~dest_full_in & |eligible`. `pop_out = go ? onehot(sel) : 0`.
- On an edge with `go`:
  - `data_out <= data_in[sel]`, `valid_out <= 1`, `grant_out <= sel`, `owner <= sel`, state → SERVE.
  - `cnt <= 1` on rotate or re-win after `cnt == BURST`; otherwise `cnt <= cnt+1`.
- On an edge with `enb=1` and no `go`, `valid_out <= 0`:
  - `dest_full_in=1` while in SERVE or STALL → STALL, with `owner` and `cnt` held.
  - `~|eligible` → IDLE, with `cnt <= 0` and `owner` held.
- On an edge with `enb=0`: all registers hold except `valid_out <= 0`.
- Pause or empty on `owner` mid-burst causes an immediate rotation in the same cycle. No idle cycle is inserted.

## Timing
- Reset values: state IDLE, `owner=3` (so channel 0 wins first), `cnt=0`, `grant_out=0`, `data_out=0`, `valid_out=0`, `pop_out=0`. Counters are 0 when `ARB_STATS_EN` is defined.
- `pop_out` is combinational from current state and inputs. The FIFO pops on the same edge that captures `data_out`.
- Latency: `valid_out`/`data_out` appear one cycle after the `pop_out` cycle.
- Throughput: one word per cycle while `go` holds.
- `dest_full_in` has zero-cycle effect: `pop_out` is forced 0 in the same cycle.
- `rst` asserted mid-burst clears everything asynchronously. No pop occurs during reset.

## Configuration
- `ARB_STATS_EN` defined:
  - Adds `grant_cnt_out`. Counter i increments on each edge with `pop_out[i]=1`.
  - Counters saturate at `2^CW-1` and clear on `rst`.
- Not defined: the port and counters are absent. Arbitration is identical.

## Test plan
- Reset: `rst=1` with random inputs → `pop_out=0`, `valid_out=0`, `data_out=0`, `grant_out=0`. First grant after release is channel 0.
- Fair rotation: all `empty_in=0`, `pausa_in=0`, `BURST=4` → pops 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0. Each `data_out` matches its popped head one cycle later.
- Pause mid-burst: after two pops of channel 0, set `pausa_in=4'b0001` → next pop is channel 1 (new burst, `cnt=1`). On return, channel 0 gets a fresh burst of 4.
- Sole eligible: only channel 2 non-empty → channel 2 popped every cycle past BURST with no gap, `cnt` wrapping to 1.
- Backpressure: `dest_full_in=1` for 3 cycles at channel 1, `cnt=2` → `pop_out=0`, `valid_out=0`, state STALL. After release, channel 1 pops 2 more, then channel 2.
- Enable/reset mid-burst: `enb=0` for 2 cycles → no pops and the burst resumes where it left off. Async `rst` pulse → outputs zero immediately and restart at channel 0. With `ARB_STATS_EN`, counters read 0.
